// File: rtl/seq_sub_pkg.sv
// Shared types and helpers for the chunk-serial subtractor.
// The state enum is kept here so that anything observing the FSM
// (debug taps, future wrappers) sees one definition of it.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n chunks; at least one bit so a single-chunk
    // configuration still has a legal (if unused) counter register.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// One CHUNK-bit slice of the subtractor: d = x - y - bin with the
// borrow-out taken from the extra high bit of a CHUNK+1 bit difference.
// Kept as its own module so the slice subtractor is reported separately
// from the sequencing logic in synthesis.
module sub_chunk
    import seq_sub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    // Widened subtraction so the wrap-around shows up as the borrow bit.
    always_comb begin
        {bout, d} = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
    end

endmodule

// File: rtl/seq_sub.sv
// Iterative unsigned subtractor: out = (a - b) mod 2^WIDTH, computed
// CHUNK bits per clock with the borrow held in a register between
// chunks. Valid/ready on both sides; one operation in flight at a time.
// out/borrow_out/zero keep the last completed result outside DONE, but
// out may show partially written chunks while RUN is in progress, so
// only out_valid qualifies them.
module seq_sub
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             zero
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int CW         = cntWidth(NUM_CHUNKS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHUNKS - 1);

    generate
        if (CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_badChunk
            $error("seq_sub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             state;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH-1:0]   outReg;
    logic [CW-1:0]      chunkIdx;
    logic               borrowReg;
    logic               borrowOutReg;
    logic               zeroReg;
    logic               inReadyReg;
    logic               outValidReg;

    logic [CHUNK-1:0]   sliceA;
    logic [CHUNK-1:0]   sliceB;
    logic [CHUNK-1:0]   chunkDiff;
    logic               chunkBorrow;
    logic [WIDTH-1:0]   nextOut;

    // Pick the operand slices for the chunk currently being processed;
    // chunk 0 is the least significant.
    always_comb begin
        sliceA = opA[int'(chunkIdx) * CHUNK +: CHUNK];
        sliceB = opB[int'(chunkIdx) * CHUNK +: CHUNK];
    end

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_subChunk (
        .x    (sliceA),
        .y    (sliceB),
        .bin  (borrowReg),
        .d    (chunkDiff),
        .bout (chunkBorrow)
    );

    // Result word with this cycle's chunk merged in, so the zero flag on
    // the last chunk sees every chunk including the one being written.
    always_comb begin
        nextOut = outReg;
        nextOut[int'(chunkIdx) * CHUNK +: CHUNK] = chunkDiff;
    end

    // Control FSM plus datapath registers; handshake outputs are registered
    // alongside the state so they change exactly with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            opA          <= '0;
            opB          <= '0;
            outReg       <= '0;
            chunkIdx     <= '0;
            borrowReg    <= 1'b0;
            borrowOutReg <= 1'b0;
            zeroReg      <= 1'b0;
            inReadyReg   <= 1'b1;
            outValidReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && inReadyReg) begin
                        opA        <= a;
                        opB        <= b;
                        chunkIdx   <= '0;
                        borrowReg  <= 1'b0;
                        inReadyReg <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    outReg    <= nextOut;
                    borrowReg <= chunkBorrow;
                    chunkIdx  <= chunkIdx + 1'b1;
                    if (chunkIdx == LAST_IDX) begin
                        borrowOutReg <= chunkBorrow;
                        zeroReg      <= ~(|nextOut);
                        outValidReg  <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValidReg <= 1'b0;
                        inReadyReg  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    outValidReg <= 1'b0;
                    inReadyReg  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = inReadyReg;
    assign out_valid  = outValidReg;
    assign out        = outReg;
    assign borrow_out = borrowOutReg;
    assign zero       = zeroReg;

endmodule

// File: tb/tb_seq_sub.sv
// Bench for seq_sub: directed corner cases on a 32/8 instance and a
// single-chunk 32/32 instance, then randomized traffic on the 32/8
// instance checked against a queue-based (a - b) reference.
`timescale 1ns/1ps
module tb_seq_sub;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    localparam int NOPS = 3000;

    logic        clock = 1'b0;
    logic        reset;

    logic        inValid, inReady, outValid, outReady;
    logic [31:0] aIn, bIn, outW;
    logic        borrowW, zeroW;

    logic        inValid1, inReady1, outValid1, outReady1;
    logic [31:0] aIn1, bIn1, outW1;
    logic        borrowW1, zeroW1;

    int          checkCount = 0;
    int          errorCount = 0;
    int          doneCount  = 0;
    bit          randomOn   = 1'b0;
    op_t         pending[$];
    op_t         popped;

    always #5 clock = ~clock;

    seq_sub #(.WIDTH(32), .CHUNK(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(inValid), .in_ready(inReady), .a(aIn), .b(bIn),
        .out_valid(outValid), .out_ready(outReady),
        .out(outW), .borrow_out(borrowW), .zero(zeroW)
    );

    seq_sub #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clock(clock), .reset(reset),
        .in_valid(inValid1), .in_ready(inReady1), .a(aIn1), .b(bIn1),
        .out_valid(outValid1), .out_ready(outReady1),
        .out(outW1), .borrow_out(borrowW1), .zero(zeroW1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Handshake one operation into the 32/8 instance and wait for its result;
    // lat is the cycle offset from the handshake cycle to the first out_valid.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 output int lat);
        int guard = 0;
        while (!inReady && guard < 50) begin
            nextCycle();
            guard++;
        end
        checkOutput("inReadyBeforeOp", 32'(inReady), 32'd1);
        inValid = 1'b1;
        aIn = av;
        bIn = bv;
        nextCycle();
        inValid = 1'b0;
        aIn = $urandom;
        bIn = $urandom;
        lat = 1;
        while (!outValid && lat < 50) begin
            nextCycle();
            lat++;
        end
        checkOutput("outValidSeen", 32'(outValid), 32'd1);
    endtask

    task automatic applySingle(input logic [31:0] av, input logic [31:0] bv,
                               output int lat);
        inValid1 = 1'b1;
        aIn1 = av;
        bIn1 = bv;
        nextCycle();
        inValid1 = 1'b0;
        lat = 1;
        while (!outValid1 && lat < 50) begin
            nextCycle();
            lat++;
        end
        checkOutput("single.outValidSeen", 32'(outValid1), 32'd1);
    endtask

    task automatic consume();
        outReady = 1'b1;
        nextCycle();
        outReady = 1'b0;
        checkOutput("afterConsume.inReady", 32'(inReady), 32'd1);
        checkOutput("afterConsume.outValid", 32'(outValid), 32'd0);
    endtask

    // Reference model: every accepted operand pair is queued; every
    // delivered result must equal the oldest pair's (a - b) mod 2^32.
    always @(negedge clock) begin
        if (randomOn) begin
            if (inReady) begin
                checkOutput("rand.noInFlightWhenReady", 32'(pending.size()), 32'd0);
                if (inValid) pending.push_back('{a: aIn, b: bIn});
            end
            if (outValid) begin
                checkOutput("rand.inReadyLowInDone", 32'(inReady), 32'd0);
            end
            if (outValid && outReady) begin
                if (pending.size() == 0) begin
                    checkOutput("rand.unexpectedResult", 32'd1, 32'd0);
                end else begin
                    popped = pending.pop_front();
                    checkOutput("rand.out", outW, popped.a - popped.b);
                    checkOutput("rand.borrow", 32'(borrowW), 32'(popped.a < popped.b));
                    checkOutput("rand.zero", 32'(zeroW), 32'(popped.a == popped.b));
                    doneCount++;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int cyc;
        int mode;
        logic [31:0] expOut;

        reset = 1'b1;
        inValid = 1'b0; aIn = '0; bIn = '0; outReady = 1'b0;
        inValid1 = 1'b0; aIn1 = '0; bIn1 = '0; outReady1 = 1'b0;
        repeat (2) nextCycle();
        checkOutput("reset.inReady", 32'(inReady), 32'd1);
        checkOutput("reset.outValid", 32'(outValid), 32'd0);
        checkOutput("reset.out", outW, 32'd0);
        checkOutput("reset.borrow", 32'(borrowW), 32'd0);
        checkOutput("reset.zero", 32'(zeroW), 32'd0);
        reset = 1'b0;
        nextCycle();

        // Borrow crossing a chunk boundary, plus latency.
        applyStimulus(32'h0000_0100, 32'h0000_0001, lat);
        checkOutput("t1.latency", 32'(lat), 32'd5);
        checkOutput("t1.out", outW, 32'h0000_00FF);
        checkOutput("t1.borrow", 32'(borrowW), 32'd0);
        checkOutput("t1.zero", 32'(zeroW), 32'd0);
        consume();

        // Borrow ripples through every chunk.
        applyStimulus(32'h0000_0000, 32'h0000_0001, lat);
        checkOutput("t2.out", outW, 32'hFFFF_FFFF);
        checkOutput("t2.borrow", 32'(borrowW), 32'd1);
        checkOutput("t2.zero", 32'(zeroW), 32'd0);
        consume();

        // Equal operands.
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, lat);
        checkOutput("t3.out", outW, 32'd0);
        checkOutput("t3.borrow", 32'(borrowW), 32'd0);
        checkOutput("t3.zero", 32'(zeroW), 32'd1);
        consume();

        // Zero minus all-ones.
        applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, lat);
        checkOutput("t4.out", outW, 32'd1);
        checkOutput("t4.borrow", 32'(borrowW), 32'd1);
        consume();

        // Backpressure held for six cycles in DONE.
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, lat);
        expOut = 32'h1234_5678 - 32'h9ABC_DEF0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("bp.outValid", 32'(outValid), 32'd1);
            checkOutput("bp.inReady", 32'(inReady), 32'd0);
            checkOutput("bp.out", outW, expOut);
            checkOutput("bp.borrow", 32'(borrowW), 32'd1);
            checkOutput("bp.zero", 32'(zeroW), 32'd0);
            nextCycle();
        end
        consume();

        // Reset in the second RUN cycle discards the operation.
        inValid = 1'b1; aIn = 32'h1111_1111; bIn = 32'h0;
        nextCycle();
        inValid = 1'b0;
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkOutput("midReset.inReady", 32'(inReady), 32'd1);
        checkOutput("midReset.outValid", 32'(outValid), 32'd0);
        checkOutput("midReset.out", outW, 32'd0);
        applyStimulus(32'd10, 32'd3, lat);
        checkOutput("afterReset.out", outW, 32'd7);
        checkOutput("afterReset.borrow", 32'(borrowW), 32'd0);
        consume();

        // Reset wins over a simultaneous handshake.
        inValid = 1'b1; aIn = 32'd99; bIn = 32'd1;
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        inValid = 1'b0;
        checkOutput("resetOverride.inReady", 32'(inReady), 32'd1);
        nextCycle();
        checkOutput("resetOverride.stillIdle", 32'(inReady), 32'd1);

        // Single-chunk instance.
        applySingle(32'd5, 32'd7, lat);
        checkOutput("single.latency", 32'(lat), 32'd2);
        checkOutput("single.out", outW1, 32'hFFFF_FFFE);
        checkOutput("single.borrow", 32'(borrowW1), 32'd1);
        checkOutput("single.zero", 32'(zeroW1), 32'd0);
        outReady1 = 1'b1;
        nextCycle();
        outReady1 = 1'b0;
        checkOutput("single.inReady", 32'(inReady1), 32'd1);
        applySingle(32'hCAFE_F00D, 32'hCAFE_F00D, lat);
        checkOutput("single.eqZero", 32'(zeroW1), 32'd1);
        checkOutput("single.eqOut", outW1, 32'd0);
        outReady1 = 1'b1;
        nextCycle();
        outReady1 = 1'b0;

        // Randomized traffic with random backpressure and idle gaps.
        randomOn = 1'b1;
        cyc = 0;
        while (doneCount < NOPS && cyc < 40000) begin
            mode = $urandom_range(0, 7);
            aIn = $urandom;
            bIn = $urandom;
            if (mode == 0) bIn = aIn;
            else if (mode == 1) begin aIn = 32'h0; bIn = 32'hFFFF_FFFF; end
            else if (mode == 2) begin aIn = $urandom_range(0, 300); bIn = $urandom_range(0, 300); end
            inValid = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 2) != 0);
            nextCycle();
            cyc++;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 20 && pending.size() != 0; i++) nextCycle();
        randomOn = 1'b0;
        outReady = 1'b0;
        checkOutput("rand.drained", 32'(pending.size()), 32'd0);
        checkOutput("rand.opsDone", 32'(doneCount >= NOPS), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
